// File: rtl/txrx_link.sv
// Transmitter/receiver pair over an internal LANE_WIDTH-bit link with a parity beat.
// Good frames land in a first-word-fall-through receive buffer; bad or dropped frames raise flags.
module txrx_link #(
    parameter int ADDR_WIDTH = 8,
    parameter int LANE_WIDTH = 2,
    parameter int RX_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         address_bus,
    input  logic                          inject_error,
    output logic                          busy,
    output logic                          ready,
    output logic [ADDR_WIDTH-1:0]         rx_address,
    input  logic                          rx_pop,
    output logic [$clog2(RX_DEPTH):0]     rx_count,
    output logic                          parity_error,
    output logic                          overflow
);

    localparam int BEATS = ADDR_WIDTH / LANE_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = $clog2(RX_DEPTH);
    localparam int CW    = PW + 1;

    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_SEND = 2'd1, TX_END = 2'd2} tx_state_e;
    typedef enum logic       {RX_IDLE = 1'b0, RX_DATA = 1'b1} rx_state_e;

    tx_state_e             tx_state_q, tx_state_d;
    logic [ADDR_WIDTH-1:0] tx_word_q, tx_word_d;
    logic                  tx_inj_q, tx_inj_d;
    logic [BW-1:0]         tx_beat_q, tx_beat_d;

    rx_state_e             rx_state_q, rx_state_d;
    logic [ADDR_WIDTH-1:0] rx_word_q, rx_word_d;
    logic [BW-1:0]         rx_beat_q, rx_beat_d;

    logic [ADDR_WIDTH-1:0] mem_q [RX_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_d [RX_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic                  busy_q, busy_d, ready_q, ready_d;
    logic                  perr_q, perr_d, ovf_q, ovf_d;

    logic                  link_valid, link_last, link_parity;
    logic [LANE_WIDTH-1:0] link_data;
    logic                  frame_done, frame_ok, frame_bad;
    logic                  do_write, do_pop, buf_full;

    // Transmit FSM: next state and link drive
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_word_d   = tx_word_q;
        tx_inj_d    = tx_inj_q;
        tx_beat_d   = tx_beat_q;
        link_valid  = 1'b0;
        link_last   = 1'b0;
        link_parity = 1'b0;
        link_data   = '0;
        case (tx_state_q)
            TX_IDLE: begin
                if (start) begin
                    tx_word_d  = address_bus;
                    tx_inj_d   = inject_error;
                    tx_beat_d  = '0;
                    tx_state_d = TX_SEND;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_SEND: begin
                link_valid = 1'b1;
                link_data  = tx_word_q[int'(tx_beat_q) * LANE_WIDTH +: LANE_WIDTH];
                if (tx_beat_q == BW'(BEATS - 1)) begin
                    tx_state_d = TX_END;
                end else begin
                    tx_beat_d = tx_beat_q + BW'(1);
                end
            end
            TX_END: begin
                link_last   = 1'b1;
                link_parity = (^tx_word_q) ^ tx_inj_q;
                // Accepting here gives back-to-back frames with no idle gap
                if (start) begin
                    tx_word_d  = address_bus;
                    tx_inj_d   = inject_error;
                    tx_beat_d  = '0;
                    tx_state_d = TX_SEND;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        busy_d = (tx_state_d != TX_IDLE);
    end

    // Receive FSM: reassemble beats and judge the frame on the parity beat
    always_comb begin
        rx_state_d = rx_state_q;
        rx_word_d  = rx_word_q;
        rx_beat_d  = rx_beat_q;
        frame_done = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (link_valid) begin
                    rx_word_d                 = '0;
                    rx_word_d[LANE_WIDTH-1:0] = link_data;
                    rx_beat_d                 = BW'(1);
                    rx_state_d                = RX_DATA;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (link_valid) begin
                    rx_word_d[int'(rx_beat_q) * LANE_WIDTH +: LANE_WIDTH] = link_data;
                    rx_beat_d = rx_beat_q + BW'(1);
                end else if (link_last) begin
                    frame_done = 1'b1;
                    rx_beat_d  = '0;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
        frame_ok  = frame_done && (link_parity == (^rx_word_q));
        frame_bad = frame_done && (link_parity != (^rx_word_q));
    end

    // Receive buffer: a pop on the write edge frees the slot the write needs
    always_comb begin
        buf_full = (count_q == CW'(RX_DEPTH));
        do_pop   = rx_pop && (count_q != CW'(0));
        do_write = frame_ok && (!buf_full || do_pop);
        mem_d    = mem_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = rx_word_q;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
        wr_ptr_d = do_write ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = do_pop   ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({do_write, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        head_d  = (count_d == CW'(0)) ? '0 : mem_d[rd_ptr_d];
        ready_d = (count_d != CW'(0));
        perr_d  = frame_bad;
        ovf_d   = ovf_q || (frame_ok && buf_full && !do_pop);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_word_q  <= '0;
            tx_inj_q   <= 1'b0;
            tx_beat_q  <= '0;
            rx_state_q <= RX_IDLE;
            rx_word_q  <= '0;
            rx_beat_q  <= '0;
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            perr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_word_q  <= tx_word_d;
            tx_inj_q   <= tx_inj_d;
            tx_beat_q  <= tx_beat_d;
            rx_state_q <= rx_state_d;
            rx_word_q  <= rx_word_d;
            rx_beat_q  <= rx_beat_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            perr_q     <= perr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy         = busy_q;
    assign ready        = ready_q;
    assign rx_address   = head_q;
    assign rx_count     = count_q;
    assign parity_error = perr_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_txrx_link.sv
// Directed self-checking bench for txrx_link at default parameters (8-bit word, 2-bit lanes, depth 4).
module tb_txrx_link;

    logic       clock, reset, start, inject_error, rx_pop;
    logic [7:0] address_bus;
    logic       busy, ready, parity_error, overflow;
    logic [7:0] rx_address;
    logic [2:0] rx_count;

    int checks = 0;
    int errors = 0;

    txrx_link #(.ADDR_WIDTH(8), .LANE_WIDTH(2), .RX_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .start(start), .address_bus(address_bus),
        .inject_error(inject_error), .busy(busy), .ready(ready), .rx_address(rx_address),
        .rx_pop(rx_pop), .rx_count(rx_count), .parity_error(parity_error), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; rx_pop = 1'b0; inject_error = 1'b0; address_bus = 8'h00;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Leaves the bench just after the accepting edge E0
    task automatic send_frame(input logic [7:0] a, input logic inj);
        start = 1'b1; address_bus = a; inject_error = inj;
        tick();
        start = 1'b0; inject_error = 1'b0;
    endtask

    // Leaves the bench just after the write edge E0+5
    task automatic send_and_wait(input logic [7:0] a);
        send_frame(a, 1'b0);
        repeat (5) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rx_pop = 1'b0; inject_error = 1'b0; address_bus = 8'h00;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", rx_count); end
        checks++; if (rx_address !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", rx_address); end
        checks++; if (parity_error !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got perr=%b ovf=%b expected 0 0", parity_error, overflow); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        send_frame(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL single_busy[%0d]: got busy=%b ready=%b expected 1 0", i, busy, ready); end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
        checks++; if (ready !== 1'b1 || rx_address !== 8'hA5) begin errors++; $display("FAIL single_rx: got ready=%b addr=%h expected 1 a5", ready, rx_address); end
        checks++; if (rx_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", rx_count); end
        checks++; if (parity_error !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL single_flags: got perr=%b ovf=%b expected 0 0", parity_error, overflow); end
    endtask

    task automatic test_order();
        do_reset();
        start = 1'b1; address_bus = 8'h01;
        tick();
        for (int f = 1; f <= 6; f++) begin
            tick(); rx_pop = 1'b0;
            tick(); tick(); tick();
            if (f < 6) address_bus = 8'(f + 1); else start = 1'b0;
            tick();
            checks++; if (ready !== 1'b1 || rx_address !== 8'(f) || rx_count !== 3'd1) begin
                errors++; $display("FAIL order[%0d]: got ready=%b addr=%h cnt=%0d expected 1 %h 1", f, ready, rx_address, rx_count, 8'(f));
            end
            rx_pop = 1'b1;
        end
        tick(); rx_pop = 1'b0;
        checks++; if (ready !== 1'b0 || rx_count !== 3'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL order_end: got ready=%b cnt=%0d ovf=%b busy=%b expected 0 0 0 0", ready, rx_count, overflow, busy);
        end
    endtask

    task automatic test_fill();
        do_reset();
        start = 1'b1; address_bus = 8'h10;
        tick();
        for (int f = 0; f < 5; f++) begin
            repeat (4) tick();
            if (f < 4) address_bus = 8'(8'h11 + f); else start = 1'b0;
            tick();
            checks++; if (rx_count !== ((f < 4) ? 3'(f + 1) : 3'd4) || overflow !== (f == 4)) begin
                errors++; $display("FAIL fill[%0d]: got cnt=%0d ovf=%b expected %0d %b", f, rx_count, overflow, (f < 4) ? f + 1 : 4, f == 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ready !== 1'b1 || rx_address !== 8'(8'h10 + i)) begin
                errors++; $display("FAIL fill_pop[%0d]: got ready=%b addr=%h expected 1 %h", i, ready, rx_address, 8'(8'h10 + i));
            end
            rx_pop = 1'b1; tick(); rx_pop = 1'b0;
        end
        checks++; if (ready !== 1'b0 || rx_count !== 3'd0 || overflow !== 1'b1) begin
            errors++; $display("FAIL fill_end: got ready=%b cnt=%0d ovf=%b expected 0 0 1", ready, rx_count, overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_words [4];
        exp_words[0] = 8'h31; exp_words[1] = 8'h32; exp_words[2] = 8'h33; exp_words[3] = 8'h20;
        do_reset();
        for (int i = 0; i < 4; i++) send_and_wait(8'(8'h30 + i));
        checks++; if (rx_count !== 3'd4) begin errors++; $display("FAIL fullpop_fill: got cnt=%0d expected 4", rx_count); end
        send_frame(8'h20, 1'b0);
        repeat (4) tick();
        rx_pop = 1'b1; tick(); rx_pop = 1'b0;
        checks++; if (rx_count !== 3'd4 || overflow !== 1'b0 || rx_address !== 8'h31) begin
            errors++; $display("FAIL fullpop_write: got cnt=%0d ovf=%b addr=%h expected 4 0 31", rx_count, overflow, rx_address);
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_address !== exp_words[i]) begin errors++; $display("FAIL fullpop_drain[%0d]: got %h expected %h", i, rx_address, exp_words[i]); end
            rx_pop = 1'b1; tick(); rx_pop = 1'b0;
        end
        checks++; if (ready !== 1'b0 || rx_count !== 3'd0) begin errors++; $display("FAIL fullpop_end: got ready=%b cnt=%0d expected 0 0", ready, rx_count); end
    endtask

    task automatic test_parity();
        do_reset();
        send_frame(8'h3C, 1'b1);
        repeat (4) tick();
        checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL parity_early: got %b expected 0", parity_error); end
        tick();
        checks++; if (parity_error !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL parity_pulse: got perr=%b ready=%b expected 1 0", parity_error, ready); end
        tick();
        checks++; if (parity_error !== 1'b0 || ready !== 1'b0 || rx_count !== 3'd0) begin errors++; $display("FAIL parity_after: got perr=%b ready=%b cnt=%0d expected 0 0 0", parity_error, ready, rx_count); end
        send_and_wait(8'h3C);
        checks++; if (ready !== 1'b1 || rx_address !== 8'h3C || parity_error !== 1'b0) begin
            errors++; $display("FAIL parity_clean: got ready=%b addr=%h perr=%b expected 1 3c 0", ready, rx_address, parity_error);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(8'hFF, 1'b0);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (busy !== 1'b0 || ready !== 1'b0 || rx_count !== 3'd0 || rx_address !== 8'h00 || parity_error !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL midreset_outs: got busy=%b ready=%b cnt=%0d addr=%h perr=%b ovf=%b expected all 0", busy, ready, rx_count, rx_address, parity_error, overflow);
        end
        repeat (6) tick();
        checks++; if (ready !== 1'b0 || rx_count !== 3'd0 || parity_error !== 1'b0) begin
            errors++; $display("FAIL midreset_later: got ready=%b cnt=%0d perr=%b expected 0 0 0", ready, rx_count, parity_error);
        end
    endtask

    task automatic test_ignored_start();
        do_reset();
        send_frame(8'h55, 1'b0);
        tick();
        start = 1'b1; address_bus = 8'hAA;
        tick();
        start = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || rx_count !== 3'd1 || rx_address !== 8'h55) begin
            errors++; $display("FAIL ignored_first: got busy=%b cnt=%0d addr=%h expected 0 1 55", busy, rx_count, rx_address);
        end
        repeat (6) tick();
        checks++; if (rx_count !== 3'd1) begin errors++; $display("FAIL ignored_extra: got cnt=%0d expected 1", rx_count); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rx_pop = 1'b0; inject_error = 1'b0; address_bus = 8'h00;
        test_reset();
        test_single();
        test_order();
        test_fill();
        test_full_pop();
        test_parity();
        test_reset_mid();
        test_ignored_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
